clkdiv_gate_multi: RTL and testbench



---
 rtl/clkdiv_gate_multi.sv | 156 +++++++++++++++
 tb/tb_clkdiv_gate_multi.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_gate_multi.sv
// Multi-channel programmable clock divider with glitch-free enable and
// boundary-aligned ratio updates; every divided output is a flop.
//
// state | meaning
// IDLE  | channel parked, Y held low, waiting for synchronised EN and N != 0
// RUN   | generating periods of N cycles, high for ceil(N/2) cycles
module clkdiv_gate_multi #(
  parameter int NCH         = 4,
  parameter int DIVW        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RESET_DIV   = 2
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic [NCH-1:0]      EN,
  input  logic [NCH*DIVW-1:0] DIV,
  input  logic [NCH-1:0]      LOAD,
  output logic [NCH-1:0]      Y,
  output logic [NCH-1:0]      ACTIVE,
  output logic [NCH-1:0]      PEND
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DIVW-1:0] RATIO_ONE = DIVW'(1);
  localparam logic [DIVW-1:0] RATIO_TWO = DIVW'(2);
  localparam logic [DIVW-1:0] RATIO_RST = DIVW'(RESET_DIV);

  // A stored ratio of 1 cannot make a 50% clock, so it runs as 2.
  function automatic logic [DIVW-1:0] eff_ratio(input logic [DIVW-1:0] r);
    return (r == RATIO_ONE) ? RATIO_TWO : r;
  endfunction

  function automatic logic [DIVW-1:0] high_len(input logic [DIVW-1:0] n);
    logic [DIVW:0] sum;
    sum = {1'b0, n} + {{DIVW{1'b0}}, 1'b1};
    return sum[DIVW:1];
  endfunction

  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [NCH-1:0]         en_s;

  state_t          state_q  [NCH];
  state_t          state_d  [NCH];
  logic [DIVW-1:0] cnt_q    [NCH];
  logic [DIVW-1:0] cnt_d    [NCH];
  logic [DIVW-1:0] ratio_q  [NCH];
  logic [DIVW-1:0] ratio_d  [NCH];
  logic [DIVW-1:0] shadow_q [NCH];
  logic [DIVW-1:0] shadow_d [NCH];
  logic [NCH-1:0]  y_q, y_d;
  logic [NCH-1:0]  pend_q, pend_d;

  logic [DIVW-1:0] div_slice [NCH];
  logic [DIVW-1:0] sel_ratio [NCH];
  logic [DIVW-1:0] n_cur     [NCH];
  logic [DIVW-1:0] n_sel     [NCH];
  logic [NCH-1:0]  boundary;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign en_s[gi]      = sync_q[gi][SYNC_STAGES-1];
    assign div_slice[gi] = DIV[gi*DIVW +: DIVW];
    // Ratio that would take effect now: a same-edge LOAD beats a pending one.
    assign sel_ratio[gi] = LOAD[gi]   ? div_slice[gi] :
                           pend_q[gi] ? shadow_q[gi]  : ratio_q[gi];
    assign n_cur[gi]     = eff_ratio(ratio_q[gi]);
    assign n_sel[gi]     = eff_ratio(sel_ratio[gi]);
    assign boundary[gi]  = (cnt_q[gi] == n_cur[gi] - RATIO_ONE);
    assign ACTIVE[gi]    = (state_q[gi] == RUN);
  end

  assign Y    = y_q;
  assign PEND = pend_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < NCH; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], EN[i]};
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= IDLE;
        cnt_q[i]    <= '0;
        ratio_q[i]  <= RATIO_RST;
        shadow_q[i] <= RATIO_RST;
      end
      y_q    <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        ratio_q[i]  <= ratio_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      y_q    <= y_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      ratio_d[i]  = ratio_q[i];
      shadow_d[i] = shadow_q[i];
      y_d[i]      = y_q[i];
      pend_d[i]   = pend_q[i];

      if (LOAD[i]) begin
        shadow_d[i] = div_slice[i];
        pend_d[i]   = 1'b1;
      end

      case (state_q[i])
        IDLE: begin
          y_d[i]   = 1'b0;
          cnt_d[i] = '0;
          if (en_s[i] && (n_sel[i] != '0)) begin
            state_d[i] = RUN;
            ratio_d[i] = sel_ratio[i];
            pend_d[i]  = 1'b0;
            y_d[i]     = 1'b1;
          end else if (!LOAD[i] && pend_q[i]) begin
            ratio_d[i] = shadow_q[i];
            pend_d[i]  = 1'b0;
          end
        end
        RUN: begin
          if (boundary[i]) begin
            ratio_d[i] = sel_ratio[i];
            pend_d[i]  = 1'b0;
            cnt_d[i]   = '0;
            // Stopping only here keeps the last low phase at full length.
            if (!en_s[i] || (n_sel[i] == '0)) begin
              state_d[i] = IDLE;
              y_d[i]     = 1'b0;
            end else begin
              y_d[i]     = 1'b1;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + RATIO_ONE;
            y_d[i]   = ((cnt_q[i] + RATIO_ONE) < high_len(n_cur[i]));
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_gate_multi.sv
// Directed plus randomised bench for clkdiv_gate_multi against a
// timestamp-based model of each channel's periods.
module tb_clkdiv_gate_multi;
  localparam int NCH       = 4;
  localparam int DIVW      = 8;
  localparam int SYNC      = 2;
  localparam int RESET_DIV = 2;

  logic                CLK = 1'b0;
  logic                RN  = 1'b0;
  logic [NCH-1:0]      EN   = '0;
  logic [NCH-1:0]      LOAD = '0;
  logic [NCH*DIVW-1:0] DIV  = '0;
  logic [NCH-1:0]      Y, ACTIVE, PEND;

  clkdiv_gate_multi #(
    .NCH(NCH), .DIVW(DIVW), .SYNC_STAGES(SYNC), .RESET_DIV(RESET_DIV)
  ) dut (
    .CLK(CLK), .RN(RN), .EN(EN), .DIV(DIV), .LOAD(LOAD),
    .Y(Y), .ACTIVE(ACTIVE), .PEND(PEND)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int ecount      = 0;

  // Model: each running channel is a period of m_n cycles that began at
  // edge m_start; Y is high for the first ceil(m_n/2) edges of it.
  logic [NCH-1:0] en_hist [$];
  bit m_run   [NCH];
  bit m_pend  [NCH];
  int m_start [NCH];
  int m_n     [NCH];
  int m_ratio [NCH];
  int m_shd   [NCH];
  logic [NCH-1:0] exp_y, exp_act, exp_pend;

  function automatic int eff(input int r);
    return (r == 1) ? 2 : r;
  endfunction

  task automatic model_reset();
    en_hist.delete();
    for (int c = 0; c < NCH; c++) begin
      m_run[c]   = 1'b0;
      m_pend[c]  = 1'b0;
      m_start[c] = 0;
      m_n[c]     = 0;
      m_ratio[c] = RESET_DIV;
      m_shd[c]   = RESET_DIV;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < NCH; c++) begin
      exp_y[c]    = m_run[c] && ((ecount - m_start[c]) < (m_n[c] + 1) / 2);
      exp_act[c]  = m_run[c];
      exp_pend[c] = m_pend[c];
    end
    vectors++;
    assert (Y === exp_y) else begin
      miscompares++;
      $error("FAIL %s Y edge=%0d obs=%b exp=%b", tag, ecount, Y, exp_y);
    end
    vectors++;
    assert (ACTIVE === exp_act) else begin
      miscompares++;
      $error("FAIL %s ACTIVE edge=%0d obs=%b exp=%b", tag, ecount, ACTIVE, exp_act);
    end
    vectors++;
    assert (PEND === exp_pend) else begin
      miscompares++;
      $error("FAIL %s PEND edge=%0d obs=%b exp=%b", tag, ecount, PEND, exp_pend);
    end
  endtask

  task automatic set_div(input int ch, input int val);
    DIV[ch*DIVW +: DIVW] = DIVW'(val);
  endtask

  task automatic step(input string tag = "step");
    logic [NCH-1:0] ens_v;
    int divc, sel;
    @(posedge CLK);
    ecount++;
    ens_v = (en_hist.size() == SYNC) ? en_hist[0] : '0;
    en_hist.push_back(EN);
    if (en_hist.size() > SYNC) void'(en_hist.pop_front());
    for (int c = 0; c < NCH; c++) begin
      divc = int'(DIV[c*DIVW +: DIVW]);
      sel  = LOAD[c] ? divc : (m_pend[c] ? m_shd[c] : m_ratio[c]);
      if (!m_run[c]) begin
        if (LOAD[c]) begin
          m_shd[c]  = divc;
          m_pend[c] = 1'b1;
        end
        if (ens_v[c] && eff(sel) != 0) begin
          m_run[c]   = 1'b1;
          m_ratio[c] = sel;
          m_pend[c]  = 1'b0;
          m_start[c] = ecount;
          m_n[c]     = eff(sel);
        end else if (!LOAD[c] && m_pend[c]) begin
          m_ratio[c] = m_shd[c];
          m_pend[c]  = 1'b0;
        end
      end else if (ecount == m_start[c] + m_n[c]) begin
        if (LOAD[c]) m_shd[c] = divc;
        m_ratio[c] = sel;
        m_pend[c]  = 1'b0;
        if (!ens_v[c] || eff(sel) == 0) m_run[c] = 1'b0;
        else begin
          m_start[c] = ecount;
          m_n[c]     = eff(sel);
        end
      end else if (LOAD[c]) begin
        m_shd[c]  = divc;
        m_pend[c] = 1'b1;
      end
    end
    #1;
    LOAD = '0;
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int t = 0; t < n; t++) step(tag);
  endtask

  task automatic wait_phase(input int ch, input int n, input int pos,
                            input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (m_run[ch] && m_n[ch] == n && (ecount - m_start[ch]) == pos) begin
        hit = 1'b1;
        break;
      end
      step(tag);
    end
    vectors++;
    assert (hit) else begin
      miscompares++;
      $error("FAIL %s wait ch%0d obs=not_reached exp=N%0d_pos%0d", tag, ch, n, pos);
    end
  endtask

  task automatic do_reset(input string tag);
    RN = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    @(posedge CLK);
    #1;
    check_outputs(tag);
    @(posedge CLK);
    #1;
    RN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at edge %0d", ecount);
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_at;
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge CLK);
    #1;
    RN = 1'b1;

    // Channel 0 from reset ratio: first rise on the third edge after EN.
    EN[0]   = 1'b1;
    rise_at = 0;
    for (int t = 1; t <= SYNC + 2; t++) begin
      step("ch0_start");
      if (rise_at == 0 && Y[0] === 1'b1) rise_at = t;
    end
    vectors++;
    assert (rise_at == SYNC + 1) else begin
      miscompares++;
      $error("FAIL ch0_latency obs=%0d exp=%0d", rise_at, SYNC + 1);
    end
    run(8, "ch0_div2");

    // Channel 1: ratio loaded while idle, then enabled.
    LOAD[1] = 1'b1;
    set_div(1, 5);
    step("ch1_load");
    step("ch1_apply");
    EN[1] = 1'b1;
    run(16, "ch1_div5");

    // Channel 0: move to 4, then load 7 mid-period.
    LOAD[0] = 1'b1;
    set_div(0, 4);
    step("ch0_load4");
    wait_phase(0, 4, 1, 20, "ch0_to4");
    LOAD[0] = 1'b1;
    set_div(0, 7);
    run(22, "ch0_div7");

    // Channel 2: N=6, disabled at cnt=1, must finish the period.
    LOAD[2] = 1'b1;
    set_div(2, 6);
    EN[2] = 1'b1;
    step("ch2_load");
    wait_phase(2, 6, 1, 20, "ch2_to6");
    EN[2] = 1'b0;
    run(12, "ch2_stop");

    // Channel 3: N=3, stop via ratio 0, restart via ratio 1.
    LOAD[3] = 1'b1;
    set_div(3, 3);
    EN[3] = 1'b1;
    step("ch3_load");
    wait_phase(3, 3, 0, 20, "ch3_to3");
    LOAD[3] = 1'b1;
    set_div(3, 0);
    run(8, "ch3_zero");
    LOAD[3] = 1'b1;
    set_div(3, 1);
    run(10, "ch3_div1");

    // Channel 1: short EN dropout inside a period does not stop it.
    wait_phase(1, 5, 0, 20, "ch1_sync");
    EN[1] = 1'b0;
    step("ch1_drop");
    EN[1] = 1'b1;
    run(12, "ch1_glitch");

    // Random enables and loads across all channels.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 15) == 0) EN[c] = ~EN[c];
        if ($urandom_range(0, 11) == 0) begin
          LOAD[c] = 1'b1;
          set_div(c, int'($urandom_range(0, 9)));
        end
      end
      step("random");
    end

    // All channels at N=6, then reset in the middle of the high phase.
    EN = '1;
    for (int c = 0; c < NCH; c++) begin
      LOAD[c] = 1'b1;
      set_div(c, 6);
    end
    step("all_load6");
    wait_phase(0, 6, 1, 40, "all_to6");
    do_reset("reset_mid");
    run(12, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
